// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: instruction-memory read port plus the opcode stream to the datapath.
// master = fetch unit side, slave = memory and consumer side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_opcode;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_opcode, instr_pc,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_opcode, instr_pc,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory reads feeding a DEPTH-entry prefetch queue; redirect flushes.
// Optional FETCH_STATS_EN adds perf_fetched / perf_dropped counters.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      bus,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [15:0]       perf_dropped
`endif
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] opc_q [DEPTH];
  logic [DATA_W-1:0] opc_d [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [ADDR_W-1:0] pcs_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop, reissue;
  logic [CNT_W-1:0]  count_after;
  logic              unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Redirect wins over ack and pop: no push, no pop in a redirect cycle.
  always_comb begin
    push        = (state_q == WAIT) && bus.mem_ack && !redirect;
    pop         = (count_q != '0) && bus.instr_ready && !redirect;
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    reissue     = push && (count_after < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!redirect && (count_q < DEPTH_C)) state_d = WAIT;
      WAIT: begin
        if (redirect)         state_d = bus.mem_ack ? IDLE : DROP;
        else if (bus.mem_ack) state_d = reissue ? WAIT : IDLE;
      end
      DROP: if (bus.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d  = (state_d != IDLE);
    mem_addr_d = mem_addr_q;
    if ((state_q == IDLE) && (state_d == WAIT)) mem_addr_d = fetch_pc_q;
    else if (reissue)                           mem_addr_d = fetch_pc_q + PC_STEP;

    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    else if (push) fetch_pc_d = fetch_pc_q + PC_STEP;

    opc_d    = opc_q;
    pcs_d    = pcs_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_after;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        opc_d[wr_ptr_q] = bus.mem_rdata;
        pcs_d[wr_ptr_q] = mem_addr_q;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        opc_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      opc_q      <= opc_d;
      pcs_q      <= pcs_d;
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.instr_valid  = (count_q != '0);
  assign bus.instr_opcode = opc_q[rd_ptr_q];
  assign bus.instr_pc     = pcs_q[rd_ptr_q];
  assign fetch_pc         = fetch_pc_q;
  assign busy             = (state_q != IDLE);

`ifdef FETCH_STATS_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_dropped_q, perf_dropped_d;
  logic        discard;

  // Dropped = discarded acks plus every entry thrown away by a flush.
  always_comb begin
    discard        = bus.mem_ack && ((state_q == DROP) || ((state_q == WAIT) && redirect));
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 16'(discard);
    if (redirect) perf_dropped_d = perf_dropped_d + 16'(count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level queue model, plus directed corner cases.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] fetch_pc, fetch_pc2;
  logic          busy, busy2;
  logic          zero_bit;
  logic [AW-1:0] zero_addr;
`ifdef FETCH_STATS_EN
  logic [31:0]   perf_fetched, pf2;
  logic [15:0]   perf_dropped, pd2;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus(bus), .fetch_pc(fetch_pc), .busy(busy)
`ifdef FETCH_STATS_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  // Second instance checks address wrap; its memory always acks and the consumer always accepts.
  assign zero_bit         = 1'b0;
  assign zero_addr        = '0;
  assign bus2.mem_ack     = bus2.mem_req;
  assign bus2.mem_rdata   = word_of(bus2.mem_addr);
  assign bus2.instr_ready = 1'b1;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .redirect(zero_bit), .redirect_pc(zero_addr),
    .bus(bus2), .fetch_pc(fetch_pc2), .busy(busy2)
`ifdef FETCH_STATS_EN
    , .perf_fetched(pf2), .perf_dropped(pd2)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected queue contents (PCs), outstanding request and next fetch address.
  logic [31:0] mq[$];
  bit          m_out, m_drop;
  logic [31:0] m_fetch, m_cur;
  int unsigned m_fetched, m_dropped;
  int          ack_cnt;
  logic [31:0] last_ack_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit redir, input logic [31:0] rpc, input bit ack, input bit rdy);
    int occ = mq.size();
    if (redir) begin
      m_dropped += mq.size() + ((m_out && ack) ? 1 : 0);
      mq.delete();
      if (m_out && !ack) m_drop = 1'b1;
      else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      m_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (occ != 0 && rdy) begin
        void'(mq.pop_front());
        m_fetched++;
      end
      if (m_out) begin
        if (ack) begin
          if (m_drop) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
            m_dropped++;
          end else begin
            mq.push_back(m_cur);
            m_fetch = m_fetch + 32'd4;
            if (mq.size() < DEPTH) m_cur = m_fetch;
            else m_out = 1'b0;
          end
        end
      end else if (occ < DEPTH) begin
        m_out = 1'b1;
        m_cur = m_fetch;
      end
    end
  endtask

  task automatic compare();
    check("mem_req", bus.mem_req, m_out);
    check("busy", busy, m_out);
    if (m_out) check("mem_addr", bus.mem_addr, m_cur);
    check("fetch_pc", fetch_pc, m_fetch);
    check("instr_valid", bus.instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("instr_pc", bus.instr_pc, mq[0]);
      check("instr_opcode", bus.instr_opcode, word_of(mq[0]));
    end
`ifdef FETCH_STATS_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_dropped", {16'h0, perf_dropped}, {16'h0, 16'(m_dropped)});
`endif
  endtask

  task automatic step(input bit rdy, input int ack_pct, input bit redir, input logic [31:0] rpc);
    bit a;
    @(negedge clk);
    a = bus.mem_req && ($urandom_range(1, 100) <= ack_pct);
    bus.mem_ack     = a;
    bus.mem_rdata   = a ? word_of(bus.mem_addr) : $urandom;
    bus.instr_ready = rdy;
    redirect        = redir;
    redirect_pc     = rpc;
    if (a) begin
      ack_cnt++;
      last_ack_addr = bus.mem_addr;
    end
    @(posedge clk);
    model_edge(redir, rpc, a, rdy);
    #1;
    compare();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_instr_pc", bus.instr_pc, 0);
    check("rst_opcode", bus.instr_opcode, 0);
    check("rst2_mem_addr", bus2.mem_addr, 32'hFFFF_FFFC);
    check("rst2_fetch_pc", fetch_pc2, 32'hFFFF_FFFC);
    reset = 1'b0;
    mq.delete();
    m_out     = 1'b0;
    m_drop    = 1'b0;
    m_fetch   = 32'h0;
    m_cur     = 32'h0;
    m_fetched = 0;
    m_dropped = 0;
    ack_cnt   = 0;
  endtask

  initial begin
    // Streaming with same-cycle acks, consumer always ready; wrap instance in parallel.
    reset_dut();
    step(1, 100, 0, 0);
    check("A_addr0", bus.mem_addr, 32'h0);
    check("W_addr0", bus2.mem_addr, 32'hFFFF_FFFC);
    step(1, 100, 0, 0);
    check("A_addr1", bus.mem_addr, 32'h4);
    check("A_pc0", bus.instr_pc, 32'h0);
    check("W_addr1", bus2.mem_addr, 32'h0);
    check("W_pc0", bus2.instr_pc, 32'hFFFF_FFFC);
    step(1, 100, 0, 0);
    check("A_addr2", bus.mem_addr, 32'h8);
    check("A_pc1", bus.instr_pc, 32'h4);
    check("W_pc1", bus2.instr_pc, 32'h0);
    repeat (5) step(1, 100, 0, 0);

    // Consumer stalled: queue fills after exactly DEPTH pushes, then a single pop frees one slot.
    reset_dut();
    repeat (8) step(0, 100, 0, 0);
    check("B_pushes", ack_cnt, 4);
    check("B_req_idle", bus.mem_req, 0);
    check("B_busy_idle", busy, 0);
    ack_cnt = 0;
    step(1, 100, 0, 0);
    repeat (5) step(0, 100, 0, 0);
    check("B_refill_cnt", ack_cnt, 1);
    check("B_refill_addr", last_ack_addr, 32'h10);

    // Slow memory: request held for three cycles before the ack.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      check("C_req", bus.mem_req, 1);
      check("C_addr", bus.mem_addr, 32'h0);
      check("C_busy", busy, 1);
    end
    step(0, 100, 0, 0);
    check("C_ack_addr", last_ack_addr, 32'h0);
    check("C_valid", bus.instr_valid, 1);

    // Redirect to 0x103 while the request at 0x8 is outstanding.
    reset_dut();
    repeat (3) step(0, 100, 0, 0);
    check("D_pre_addr", bus.mem_addr, 32'h8);
    step(0, 0, 1, 32'h103);
    check("D_flush_valid", bus.instr_valid, 0);
    check("D_drop_busy", busy, 1);
    check("D_drop_addr", bus.mem_addr, 32'h8);
    check("D_fetch_pc", fetch_pc, 32'h100);
    step(0, 100, 0, 0);
    check("D_discard_valid", bus.instr_valid, 0);
    check("D_idle_busy", busy, 0);
    step(0, 100, 0, 0);
    check("D_new_addr", bus.mem_addr, 32'h100);
    step(1, 100, 0, 0);
    check("D_first_valid", bus.instr_valid, 1);
    check("D_first_pc", bus.instr_pc, 32'h100);
`ifdef FETCH_STATS_EN
    check("D_perf_dropped", {16'h0, perf_dropped}, 32'd3);
    check("D_perf_fetched", perf_fetched, 32'd0);
`endif

    // Redirect, ack and pop in the same cycle.
    reset_dut();
    repeat (2) step(0, 100, 0, 0);
    check("E_pre_valid", bus.instr_valid, 1);
    step(1, 100, 1, 32'h200);
    check("E_valid", bus.instr_valid, 0);
    check("E_req", bus.mem_req, 0);
    check("E_busy", busy, 0);
    check("E_fetch_pc", fetch_pc, 32'h200);
    step(0, 100, 0, 0);
    check("E_new_addr", bus.mem_addr, 32'h200);
`ifdef FETCH_STATS_EN
    check("E_perf_dropped", {16'h0, perf_dropped}, 32'd2);
`endif

    // Randomized traffic: variable ack latency, stalls and redirects.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, 40, $urandom_range(0, 24) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
